// File: rtl/twoof5_scan_ctrl.sv
// twoof5_scan_ctrl
// Time-multiplexed scan controller for a 2-of-5 seven-segment display.
// Holds one 5-bit 2-of-5 code per digit and validates each code as it is
// written. Drives one stored code at a time on the shared E1..E5 bus, with
// a one-hot digit enable and a blank gap between digits to avoid ghosting.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   en_i         scan enable
//   load_i       write strobe for one digit code
//   digit_idx_i  target digit for load_i
//   code_in_i    2-of-5 code, bit4=E1 .. bit0=E5
//   load_ack_o   one-cycle pulse after an accepted load
//   code_out_o   shared bus to the segment decoders, bit4=E1 .. bit0=E5
//   digit_sel_o  one-hot active-high digit enable
//   blank_o      high when no digit is lit
//   err_o        per-digit sticky "invalid code stored" flag
//
// State table
//   state   | meaning
//   S_OFF   | scan disabled, outputs blank
//   S_BLANK | inter-digit gap, outputs blank for GAP cycles
//   S_DRIVE | current digit driven for PRESCALE cycles (blank if invalid)

module twoof5_scan_ctrl #(
   parameter  int DIGITS   = 4,
   parameter  int PRESCALE = 1000,
   parameter  int GAP      = 2,
   localparam int IW       = $clog2(DIGITS)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              en_i,
   input  logic              load_i,
   input  logic [IW-1:0]     digit_idx_i,
   input  logic [4:0]        code_in_i,
   output logic              load_ack_o,
   output logic [4:0]        code_out_o,
   output logic [DIGITS-1:0] digit_sel_o,
   output logic              blank_o,
   output logic [DIGITS-1:0] err_o
);

   localparam int TMAX = (PRESCALE > GAP) ? PRESCALE : GAP;
   localparam int TW   = $clog2(TMAX + 1);

   localparam logic [TW-1:0] GAP_LAST   = TW'(GAP - 1);
   localparam logic [TW-1:0] DRIVE_LAST = TW'(PRESCALE - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
   localparam logic [IW:0]   IDX_LIMIT  = (IW + 1)'(DIGITS);

   typedef enum logic [1:0] {
      S_OFF   = 2'd0,
      S_BLANK = 2'd1,
      S_DRIVE = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [TW-1:0]           timer_q, timer_d;
   logic [DIGITS-1:0][4:0]  store_q;
   logic [DIGITS-1:0]       valid_q;
   logic [DIGITS-1:0]       err_q;
   logic                    load_ack_q;
   logic [4:0]              code_out_q;
   logic [DIGITS-1:0]       digit_sel_q;
   logic                    blank_q;

   logic                    load_ok;
   logic                    code_ok;
   logic                    drive_ok;

   // Out-of-range indices only exist when DIGITS is not a power of two.
   assign load_ok  = load_i && ({1'b0, digit_idx_i} < IDX_LIMIT);
   assign code_ok  = ($countones(code_in_i) == 2);

   // Outputs follow the next state but read the code store as it was before
   // this edge, so a write to the driven digit shows up one cycle later.
   assign drive_ok = (state_d == S_DRIVE) && valid_q[idx_d];

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      timer_d = timer_q + TW'(1);
      if (!en_i) begin
         state_d = S_OFF;
         idx_d   = '0;
         timer_d = '0;
      end else begin
         case (state_q)
            S_OFF: begin
               state_d = S_BLANK;
               idx_d   = '0;
               timer_d = '0;
            end
            S_BLANK: begin
               if (timer_q == GAP_LAST) begin
                  state_d = S_DRIVE;
                  timer_d = '0;
               end
            end
            S_DRIVE: begin
               // Slot length is fixed whether or not the digit is valid.
               if (timer_q == DRIVE_LAST) begin
                  state_d = S_BLANK;
                  timer_d = '0;
                  idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
               end
            end
            default: begin
               state_d = S_OFF;
               idx_d   = '0;
               timer_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_OFF;
         idx_q       <= '0;
         timer_q     <= '0;
         store_q     <= '0;
         valid_q     <= '0;
         err_q       <= '0;
         load_ack_q  <= 1'b0;
         code_out_q  <= '0;
         digit_sel_q <= '0;
         blank_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         timer_q    <= timer_d;
         load_ack_q <= load_ok;

         if (load_ok) begin
            store_q[digit_idx_i] <= code_in_i;
            valid_q[digit_idx_i] <= code_ok;
            err_q[digit_idx_i]   <= !code_ok;
         end

         if (drive_ok) begin
            digit_sel_q <= DIGITS'(1) << idx_d;
            code_out_q  <= store_q[idx_d];
            blank_q     <= 1'b0;
         end else begin
            digit_sel_q <= '0;
            code_out_q  <= '0;
            blank_q     <= 1'b1;
         end
      end
   end

   assign load_ack_o  = load_ack_q;
   assign code_out_o  = code_out_q;
   assign digit_sel_o = digit_sel_q;
   assign blank_o     = blank_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_twoof5_scan_ctrl.sv
// Bench for twoof5_scan_ctrl with DIGITS=4, PRESCALE=4, GAP=1.
// A reference model derives the expected outputs from the number of edges
// since the scan was (re)started and the stored codes; a compare process
// checks it every cycle, and directed steps pin key cycles with literals.

module tb_twoof5_scan_ctrl;

   localparam int D   = 4;
   localparam int P   = 4;
   localparam int G   = 1;
   localparam int PER = D * (G + P);

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       load = 1'b0;
   logic [1:0] didx = 2'd0;
   logic [4:0] cin = 5'd0;

   logic       load_ack;
   logic [4:0] code_out;
   logic [3:0] digit_sel;
   logic       blank;
   logic [3:0] err;

   int vectors = 0;
   int miscompares = 0;

   twoof5_scan_ctrl #(
      .DIGITS  (D),
      .PRESCALE(P),
      .GAP     (G)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .en_i       (en),
      .load_i     (load),
      .digit_idx_i(didx),
      .code_in_i  (cin),
      .load_ack_o (load_ack),
      .code_out_o (code_out),
      .digit_sel_o(digit_sel),
      .blank_o    (blank),
      .err_o      (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got 'b%0b, expected 'b%0b at %0t", name, act, expv, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // m_p counts edges since the scan left OFF; the edge that leaves OFF is 0.
   logic       m_on;
   int         m_p;
   logic [4:0] m_store [D];
   logic [3:0] m_valid;
   logic [3:0] m_err;
   logic       m_ack;
   logic [3:0] exp_sel;
   logic [4:0] exp_code;
   logic       exp_blank;

   // Digit lit after the coming edge, or -1 when the bus should be blank.
   function automatic int slot_digit(logic e, logic on, int p);
      int pn;
      int q;
      if (!e) return -1;
      pn = on ? p + 1 : 0;
      q  = pn % PER;
      if ((q % (G + P)) < G) return -1;
      return q / (G + P);
   endfunction

   int         nd;
   logic [1:0] ndi;
   assign nd  = slot_digit(en, m_on, m_p);
   assign ndi = 2'(nd);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_on      <= 1'b0;
         m_p       <= 0;
         m_valid   <= '0;
         m_err     <= '0;
         m_ack     <= 1'b0;
         exp_sel   <= '0;
         exp_code  <= '0;
         exp_blank <= 1'b1;
         for (int i = 0; i < D; i++) m_store[i] <= '0;
      end else begin
         m_on <= en;
         m_p  <= (en && m_on) ? m_p + 1 : 0;
         if (nd >= 0 && m_valid[ndi]) begin
            exp_sel   <= 4'd1 << ndi;
            exp_code  <= m_store[ndi];
            exp_blank <= 1'b0;
         end else begin
            exp_sel   <= '0;
            exp_code  <= '0;
            exp_blank <= 1'b1;
         end
         m_ack <= load && (int'(didx) < D);
         if (load && (int'(didx) < D)) begin
            m_store[didx] <= cin;
            m_valid[didx] <= ($countones(cin) == 2);
            m_err[didx]   <= ($countones(cin) != 2);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("model_sel", 32'(digit_sel), 32'(exp_sel));
         chk("model_code", 32'(code_out), 32'(exp_code));
         chk("model_blank", 32'(blank), 32'(exp_blank));
         chk("model_err", 32'(err), 32'(m_err));
         chk("model_ack", 32'(load_ack), 32'(m_ack));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic do_load(input logic [1:0] i, input logic [4:0] c);
      load = 1'b1;
      didx = i;
      cin  = c;
      @(negedge clk);
   endtask

   task automatic wait_sel(input logic [3:0] t, input int maxc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxc && !ok; i++) begin
         @(negedge clk);
         if (digit_sel == t) ok = 1'b1;
      end
   endtask

   initial begin
      bit ok;

      repeat (2) @(negedge clk);
      chk("rst_blank", 32'(blank), 32'd1);
      chk("rst_sel", 32'(digit_sel), 32'd0);
      chk("rst_code", 32'(code_out), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_ack", 32'(load_ack), 32'd0);

      // Scan with nothing loaded: permanently blank, no errors.
      rst_n = 1'b1;
      en    = 1'b1;
      repeat (30) @(negedge clk);
      chk("noload_blank", 32'(blank), 32'd1);
      chk("noload_sel", 32'(digit_sel), 32'd0);
      chk("noload_err", 32'(err), 32'd0);

      // Load all digits with load held high for four cycles.
      en = 1'b0;
      @(negedge clk);
      do_load(2'd0, 5'b00011); chk("ack0", 32'(load_ack), 32'd1);
      do_load(2'd1, 5'b00101); chk("ack1", 32'(load_ack), 32'd1);
      do_load(2'd2, 5'b01001); chk("ack2", 32'(load_ack), 32'd1);
      do_load(2'd3, 5'b10001); chk("ack3", 32'(load_ack), 32'd1);
      load = 1'b0;
      @(negedge clk);
      chk("ack_drop", 32'(load_ack), 32'd0);
      chk("valid_err", 32'(err), 32'd0);
      chk("off_blank", 32'(blank), 32'd1);

      en = 1'b1;
      for (int k = 0; k <= 40; k++) begin
         @(negedge clk);
         if (k == 0) chk("start_blank", 32'(blank), 32'd1);
         if (k == 1 || k == 4) begin
            chk("d0_sel", 32'(digit_sel), 32'b0001);
            chk("d0_code", 32'(code_out), 32'b00011);
         end
         if (k == 5) chk("gap_blank", 32'(blank), 32'd1);
         if (k == 6) begin
            chk("d1_sel", 32'(digit_sel), 32'b0010);
            chk("d1_code", 32'(code_out), 32'b00101);
         end
         if (k == 16) begin
            chk("d3_sel", 32'(digit_sel), 32'b1000);
            chk("d3_code", 32'(code_out), 32'b10001);
         end
         if (k == 21) begin
            chk("wrap_sel", 32'(digit_sel), 32'b0001);
            chk("wrap_code", 32'(code_out), 32'b00011);
         end
      end

      // Invalid code on digit 2, then a valid reload.
      do_load(2'd2, 5'b00111);
      load = 1'b0;
      chk("inv_ack", 32'(load_ack), 32'd1);
      chk("inv_err", 32'(err), 32'b0100);
      repeat (PER) @(negedge clk);
      do_load(2'd2, 5'b11000);
      load = 1'b0;
      chk("fix_err", 32'(err), 32'd0);
      wait_sel(4'b0100, 2 * PER, ok);
      chk("fix_found", 32'(ok), 32'd1);
      chk("fix_code", 32'(code_out), 32'b11000);

      // Invalidate digit 1 on the first cycle of its slot.
      wait_sel(4'b0010, 2 * PER, ok);
      chk("mid_found", 32'(ok), 32'd1);
      do_load(2'd1, 5'b00000);
      load = 1'b0;
      chk("mid_old_sel", 32'(digit_sel), 32'b0010);
      @(negedge clk);
      chk("mid_blank", 32'(blank), 32'd1);
      chk("mid_sel0", 32'(digit_sel), 32'd0);
      chk("mid_err", 32'(err), 32'b0010);
      @(negedge clk);
      chk("mid_blank4", 32'(blank), 32'd1);
      @(negedge clk);
      chk("mid_gap", 32'(blank), 32'd1);
      @(negedge clk);
      chk("slot_len", 32'(digit_sel), 32'b0100);

      do_load(2'd1, 5'b00101);
      do_load(2'd3, 5'b11111);
      load = 1'b0;
      chk("five_err", 32'(err), 32'b1000);

      // Drop enable in the middle of digit 2, then restart.
      wait_sel(4'b0001, 2 * PER, ok);
      chk("d0_found", 32'(ok), 32'd1);
      wait_sel(4'b0100, 2 * PER, ok);
      chk("d2_found", 32'(ok), 32'd1);
      @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      chk("dis_blank", 32'(blank), 32'd1);
      chk("dis_sel", 32'(digit_sel), 32'd0);
      en = 1'b1;
      @(negedge clk);
      chk("re_blank", 32'(blank), 32'd1);
      @(negedge clk);
      chk("re_sel", 32'(digit_sel), 32'b0001);
      chk("re_code", 32'(code_out), 32'b00011);

      // Asynchronous reset in the middle of a drive slot.
      @(negedge clk);
      chk("pre_rst_sel", 32'(digit_sel), 32'b0001);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_sel", 32'(digit_sel), 32'd0);
      chk("arst_code", 32'(code_out), 32'd0);
      chk("arst_blank", 32'(blank), 32'd1);
      chk("arst_err", 32'(err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (PER + 5) @(negedge clk);
      chk("post_blank", 32'(blank), 32'd1);
      chk("post_sel", 32'(digit_sel), 32'd0);
      chk("post_err", 32'(err), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1);
   end

endmodule

// File: doc/twoof5_scan_ctrl.md
Name: twoof5_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 2-of-5 seven-segment display path.
- Stores one 5-bit 2-of-5 code per digit and checks each code on load.
- Cycles through the digits, presenting one stored code at a time on the shared E1..E5 bus that feeds the segment decoders (one decoder per segment A..G), with a one-hot digit enable.
- Inserts a blanking gap between digits to prevent ghosting; invalid codes are blanked and flagged.

Parameters:
- DIGITS, 4: number of multiplexed digits, minimum 2.
- PRESCALE, 1000: clock cycles each digit is driven, minimum 1.
- GAP, 2: blank cycles between digits, minimum 1.
- IW, $clog2(DIGITS): digit index width (derived).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  scan enable.
- load  in  1  write strobe for one digit code.
- digit_idx  in  IW  target digit for load.
- code_in  in  5  2-of-5 code; bit4=E1 .. bit0=E5.
- load_ack  out  1  one-cycle pulse when a load is accepted.
- code_out  out  5  shared bus to segment decoders; bit4=E1 .. bit0=E5.
- digit_sel  out  DIGITS  one-hot active-high digit enable.
- blank  out  1  high when no digit is lit.
- err  out  DIGITS  per-digit sticky "invalid code stored" flag.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: state=OFF, idx=0, timer=0, all stored codes=0, valid bits=0, code_out=0, digit_sel=0, blank=1, load_ack=0, err=0.
- All outputs are registered.
- FSM state OFF: outputs blank. If en=1, go to BLANK with idx=0 and timer=0.
- FSM state BLANK: digit_sel=0, code_out=0, blank=1. Hold for GAP cycles, then go to DRIVE.
- FSM state DRIVE: hold for PRESCALE cycles, then go to BLANK with idx=(idx==DIGITS-1)?0:idx+1.
- DRIVE outputs when valid[idx]=1: digit_sel=onehot(idx), code_out=store[idx], blank=0.
- DRIVE outputs when valid[idx]=0: digit_sel=0, code_out=0, blank=1. The digit's time slot is still consumed, so the scan period stays constant.
- Scan period is DIGITS*(GAP+PRESCALE) cycles.
- en=0 in any state: go to OFF on the next edge, idx=0, outputs blank from that edge. A later en=1 restarts at digit 0 via BLANK.
- Timer width is $clog2(max(PRESCALE,GAP)+1). The timer clears on every state change.
- Load:
  - load is sampled every edge and accepted in any state, including OFF.
  - If digit_idx<DIGITS: store[digit_idx]<=code_in, and load_ack=1 on the following cycle only.
  - If popcount(code_in)==2: valid=1 and err bit cleared.
  - Otherwise (0,1,3,4,5 ones): valid=0 and err bit set. The code is still stored.
  - If digit_idx>=DIGITS (non-power-of-2 DIGITS): load ignored, no ack, no state change.
  - load held high for N cycles performs N writes and gives N ack pulses.
- Load to the digit currently in DRIVE: the new code, or the blanking caused by an invalid code, appears on code_out/digit_sel one cycle after the write edge, mid-slot. The slot timer is not restarted.
- Reset mid-scan: all outputs return immediately (asynchronously) to reset values, and stored codes are lost.
- digit_sel never has more than one bit set. It is all-zero whenever blank=1.

Test Plan:
All scenarios use DIGITS=4, PRESCALE=4, GAP=1.
- Reset then en=1 with no loads: blank=1 and digit_sel=0 indefinitely; err=0000, since unloaded digits are invalid but not erroneous.
- Load digits 0..3 with 00011, 00101, 01001, 10001, then en=1:
  - After 1 BLANK cycle, digit_sel=0001 and code_out=00011 for exactly 4 cycles.
  - Then 1 blank cycle, then 0010/00101, continuing through the digits.
  - After digit 3, wraps to digit 0; period is 20 cycles.
- Load digit 2 with 00111: err=0100, load_ack pulses; the digit-2 slot shows blank=1 and digit_sel=0. Reloading digit 2 with 11000 clears err to 0000, and the next slot shows code_out=11000.
- Load digit 1 with 00000 during its DRIVE slot: one cycle after the write, blank=1 for the remainder of the slot. The slot length stays 4 cycles.
- Deassert en mid-DRIVE of digit 2: outputs blank on the next edge. Re-enable: BLANK for 1 cycle, then digit_sel=0001.
- Assert rst_n=0 asynchronously mid-DRIVE: digit_sel=0, code_out=0, blank=1 before the next clk edge. After release, err=0 and all stored codes=0.
